// File: rtl/wallace_tree_multiplier.sv
// wallace_tree_multiplier: unsigned 4x4 multiplier. The partial products
// are reduced by a two-layer Wallace tree of gate-level full/half adders,
// and the two rows that remain feed an 8-bit ripple carry-propagate adder.
// The 8-bit product and its valid strobe are registered.
// Optional build macro WALLACE_INPUT_REG_EN adds an input register stage
// for a, b and in_valid, which raises the latency from 1 to 2 clocks.
module wallace_tree_multiplier (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       out_valid
);

  // Full adder cell, result packed as {carry, sum}
  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    fa = {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // Half adder cell, result packed as {carry, sum}
  function automatic logic [1:0] ha(input logic x, input logic y);
    ha = {x & y, x ^ y};
  endfunction

  logic [3:0] a_p0;
  logic [3:0] b_p0;
  logic       vld_p0;

`ifdef WALLACE_INPUT_REG_EN
  // ---- stage p0: optional operand/valid capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0   <= 4'd0;
      b_p0   <= 4'd0;
      vld_p0 <= 1'b0;
    end else begin
      a_p0   <= a;
      b_p0   <= b;
      vld_p0 <= in_valid;
    end
  end
`else
  assign a_p0   = a;
  assign b_p0   = b;
  assign vld_p0 = in_valid;
`endif

  // Partial product bits; pp[i][j] carries weight 2^(i+j)
  logic [3:0] pp [4];
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = a_p0[j] & b_p0[i];
      end
    end
  end

  // Layer 1: column heights 1,2,3,4,3,2,1 -> 1,2,1,3,2,3,1.
  // Columns 2, 3 and 4 each compress one triple; everything else passes.
  logic [1:0] fa2_l1;
  logic [1:0] fa3_l1;
  logic [1:0] fa4_l1;
  assign fa2_l1 = fa(pp[0][2], pp[1][1], pp[2][0]);
  assign fa3_l1 = fa(pp[0][3], pp[1][2], pp[2][1]);
  assign fa4_l1 = fa(pp[1][3], pp[2][2], pp[3][1]);

  // Layer 2: columns 3 and 5 hold three bits and get full adders. Column 4
  // would then grow back to three (its two bits plus column 3's carry), so
  // its pair goes through a half adder; this is the only half adder needed.
  logic [1:0] fa3_l2;
  logic [1:0] ha4_l2;
  logic [1:0] fa5_l2;
  assign fa3_l2 = fa(fa3_l1[0], pp[3][0], fa2_l1[1]);
  assign ha4_l2 = ha(fa4_l1[0], fa3_l1[1]);
  assign fa5_l2 = fa(pp[2][3], pp[3][2], fa4_l1[1]);

  // Two remaining rows, every column now at height <= 2
  logic [7:0] row_x;
  logic [7:0] row_y;
  assign row_x = {1'b0, pp[3][3], fa5_l2[0], ha4_l2[0], fa3_l2[0],
                  fa2_l1[0], pp[0][1], pp[0][0]};
  assign row_y = {1'b0, fa5_l2[1], ha4_l2[1], fa3_l2[1], 2'b00,
                  pp[1][0], 1'b0};

  // Ripple carry-propagate adder built from the same full adder cell
  logic [7:0] sum_p0;
  always_comb begin
    logic       c;
    logic [1:0] r;
    c      = 1'b0;
    r      = 2'b00;
    sum_p0 = 8'd0;
    for (int k = 0; k < 8; k++) begin
      r         = fa(row_x[k], row_y[k], c);
      sum_p0[k] = r[0];
      c         = r[1];
    end
  end

  // ---- stage p1: product register, loads only on valid, valid follows ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product   <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_p0;
      if (vld_p0) begin
        product <= sum_p0;
      end
    end
  end

endmodule

// File: tb/tb_wallace_tree_multiplier.sv
// tb_wallace_tree_multiplier: directed bench for wallace_tree_multiplier.
// Build with WALLACE_INPUT_REG_EN defined to exercise the 2-clock variant.
module tb_wallace_tree_multiplier;

`ifdef WALLACE_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] product;
  logic       out_valid;

  int n_cmp;
  int n_bad;

  // Expected {out_valid, product} entries waiting for their latency to elapse
  logic [8:0] expq [$];

  wallace_tree_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .product   (product),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at a negedge; the expected output for this
  // vector is checked once LAT rising edges have passed.
  task automatic step(input logic v, input logic [3:0] x, input logic [3:0] y,
                      input logic ev, input logic [7:0] ep, input string tag);
    logic [8:0] e;
    in_valid = v;
    a        = x;
    b        = y;
    expq.push_back({ev, ep});
    @(negedge clk);
    if (expq.size() == LAT) begin
      e = expq.pop_front();
      chk({tag, ".vld"}, {7'd0, out_valid}, {7'd0, e[8]});
      chk({tag, ".prod"}, product, e[7:0]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 4'($urandom_range(15));
    b        = 4'($urandom_range(15));

    // Reset held with live operands
    repeat (3) @(negedge clk);
    chk("reset.prod", product, 8'h00);
    chk("reset.vld", {7'd0, out_valid}, 8'h00);

    // Release, then a first multiply
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    step(1'b1, 4'd3, 4'd5, 1'b1, 8'h0F, "first_3x5");
    step(1'b0, 4'd0, 4'd0, 1'b0, 8'h0F, "first_idle");

    // Back-to-back streaming
    step(1'b1, 4'd15, 4'd15, 1'b1, 8'hE1, "stream_15x15");
    step(1'b1, 4'd9,  4'd6,  1'b1, 8'h36, "stream_9x6");
    step(1'b1, 4'd0,  4'd10, 1'b1, 8'h00, "stream_0x10");

    // Hold while in_valid is low and operands move
    step(1'b1, 4'd9, 4'd6, 1'b1, 8'h36, "hold_load");
    step(1'b0, 4'd7, 4'd7, 1'b0, 8'h36, "hold_1");
    step(1'b0, 4'd7, 4'd7, 1'b0, 8'h36, "hold_2");

    // A few single-bit and edge vectors
    step(1'b1, 4'd15, 4'd1, 1'b1, 8'h0F, "edge_15x1");
    step(1'b1, 4'd8,  4'd8, 1'b1, 8'h40, "edge_8x8");
    step(1'b1, 4'd12, 4'd5, 1'b1, 8'h3C, "edge_12x5");

    // Exhaustive stream of all operand pairs
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        step(1'b1, 4'(i), 4'(j), 1'b1, 8'(i * j), $sformatf("exh_%0dx%0d", i, j));
      end
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 8'hE1, "flush_1");
    step(1'b0, 4'd0, 4'd0, 1'b0, 8'hE1, "flush_2");

    // Asynchronous reset while a 15x15 result is in flight
    in_valid = 1'b1;
    a        = 4'd15;
    b        = 4'd15;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.prod", product, 8'h00);
    chk("midrst.vld", {7'd0, out_valid}, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'd15, 4'd15, 1'b0, 8'h00, "postrst_1");
    step(1'b0, 4'd15, 4'd15, 1'b0, 8'h00, "postrst_2");
    step(1'b0, 4'd15, 4'd15, 1'b0, 8'h00, "postrst_3");
    step(1'b1, 4'd6,  4'd7,  1'b1, 8'h2A, "postrst_6x7");
    step(1'b0, 4'd0,  4'd0,  1'b0, 8'h2A, "postrst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
